divider_control: RTL and testbench

//   Sequential unsigned integer divider with a start/done handshake; one quotient bit per clock.

---
 rtl/divider_control_pkg.sv | 18 +
 rtl/divider_control_step.sv | 23 ++
 rtl/divider_control.sv | 117 +++++++++++
 tb/tb_divider_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/divider_control_pkg.sv
// Shared definitions for the sequential control engines (add / multiply / divide).
// Holds the common state enum and the helper that sizes the iteration counter.
package divider_control_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  localparam int DEF_WIDTH = 4;

  // The counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_control_step.sv
// One restoring-division iteration: shift in the next dividend bit, then subtract the
// divisor if it fits.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, msb_i};
  // When the subtraction is taken the true result is below the divisor, so the
  // truncated WIDTH-bit difference is exact.
  assign diff    = shifted[WIDTH-1:0] - divisor_i;
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_control.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Divide by zero yields quotient all ones and remainder equal to the dividend.
module divider_control
  import divider_control_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers advance only in RUN; the visible outputs load once, leaving DONE.
  always_comb begin
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = in1;
          dvs_d = in2;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CNT_LOAD;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_ONE;
      end
      DONE: begin
        quotient_d  = quo_q;
        remainder_d = rem_q;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_divider_control.sv
// Self-checking bench for divider_control (WIDTH=4): directed cases, exhaustive sweep,
// back-to-back start, mid-run reset and random operations against an arithmetic model.
module tb_divider_control;

  localparam int W = 4;
  localparam logic [W-1:0] ALL_ONES = '1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] in1, in2;
  logic [W-1:0] quotient, remainder;
  logic         done;
  logic [1:0]   state_dbg;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  divider_control #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? ALL_ONES : W'(int'(a) / int'(b));
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(int'(a) % int'(b));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Start one operation, scramble the operands after the start edge, and verify
  // latency, results, output stability during RUN and the single-cycle done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   hold_q, hold_r;
    logic [2*W-1:0] e;
    int  lat;
    bit  seen;
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    exp_q.push_back({model_q(a, b), model_r(a, b)});
    hold_q = quotient;
    hold_r = remainder;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1;
      else begin
        check("hold_q", quotient, hold_q);
        check("hold_r", remainder, hold_r);
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", lat, 5);
      e = exp_q.pop_front();
      check("quotient", quotient, e[2*W-1:W]);
      check("remainder", remainder, e[W-1:0]);
      @(posedge clk);
      #1;
      check("done_width", done, 0);
      check("q_hold_after", quotient, e[2*W-1:W]);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    #12;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(4'd13, 4'd4);
    run_op(4'd15, 4'd1);
    run_op(4'd3, 4'd7);
    run_op(4'd9, 4'd0);

    // Exhaustive sweep with reset between operations
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_reset();
        run_op(W'(a), W'(b));
      end
    end

    // start held high: restarts every 6 edges, scrambled operands during RUN ignored
    do_reset();
    ndone = 0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i % 6 == 0) begin
        in1 = 4'd14;
        in2 = 4'd3;
      end else begin
        in1 = W'($urandom);
        in2 = W'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check("b2b_phase", i % 6, 5);
        check("b2b_q", quotient, 4);
        check("b2b_r", remainder, 2);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    repeat (8) @(negedge clk);

    // Reset during RUN, after the second step edge
    run_op(4'd13, 4'd4);
    @(negedge clk);
    in1 = 4'd7;
    in2 = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    run_op(4'd11, 4'd3);

    // Random operations, including immediate restarts
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
